led_blink_code_mc: RTL
======================

# led_blink_code_mc

Parametrised multi-class health-LED blink-code sequencer. It OR-reduces NUM_CLASSES fault-class buses and selects one class, either by priority or round-robin. It emits an OFF gap followed by N low pulses on the active-low health LED, with N taken from a per-class blink map. The blink timebase comes from an internal tick divider on sys_clk, so no separate blink clock is needed. The block sits between fault aggregation logic and the front-panel health LED pin.

## Interface
- NUM_CLASSES, 11: number of fault classes (≥2); class index NUM_CLASSES-1 has highest priority.
- CLASS_SIZE, 8: bits per class bus.
- BLINK_W, 4: width of one blink-map entry and of the blink counter.
- BLINK_MAP, entry i = i+1: packed NUM_CLASSES*BLINK_W blink counts; entry i sits at bits [i*BLINK_W +: BLINK_W]; entry value 0 masks the class.
- CLK_DIV, 12_500_000: sys_clk cycles per tick (≥2); one tick is one half blink period.
- OFF_TICKS, 4: ticks of LED off before each blink burst (≥1).
- MODE, 0: 0 = priority, 1 = round-robin over active classes.
- STICKY, 0: 0 = live fault inputs, 1 = latched until clear_faults.
- sys_clk, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high reset.
- class_in, in, NUM_CLASSES*CLASS_SIZE: class i is slice [i*CLASS_SIZE +: CLASS_SIZE].
- clear_faults, in, 1: sys_clk-synchronous clear of latched faults; ignored when STICKY=0.
- health_led, out, 1: active-low; 0 = LED lit.
- active_class, out, CW = max(1, clog2(NUM_CLASSES)): class of the current or last sequence.
- seq_busy, out, 1: high whenever FSM is not IDLE.
- seq_done, out, 1: one-cycle pulse at end of each burst.
- fault_present, out, 1: |fault_vec.

## Operation
- Event detection: event[i] = |class_in slice i.
  - Live mode: fault_vec <= event every cycle.
  - Sticky mode: fault_vec <= clear_faults ? event : (fault_vec | event). A set in the same cycle as clear wins.
- Eligibility: eligible[i] = fault_vec[i] & (BLINK_MAP entry i != 0).
- Tick: free-running counter 0..CLK_DIV-1. tick is high for one cycle when the count equals CLK_DIV-1. The divider never restarts except on reset.
- FSM states:
  - IDLE: leave for SELECT when |eligible.
  - SELECT: one cycle. Choose a class:
    - Priority mode: highest eligible index.
    - Round-robin mode: lowest eligible index strictly greater than last_class, wrapping to the lowest eligible index.
    - Latch active_class and last_class, load target from BLINK_MAP, clear tick_cnt and blink_cnt, go to OFF.
    - If eligible became 0, return to IDLE with active_class unchanged.
  - OFF: count ticks; on the OFF_TICKS-th tick go to BLINK_ON.
  - BLINK_ON: on the next tick go to BLINK_OFF.
  - BLINK_OFF: on the next tick increment blink_cnt.
    - If the incremented value equals target: pulse seq_done, go to IDLE.
    - Otherwise go to BLINK_ON.
- health_led = 0 only while the state is BLINK_ON. It is driven from a flop (no combinational path from inputs).
- Fault changes during OFF, BLINK_ON or BLINK_OFF never abort or alter the running burst. This includes clear_faults and removal of the selected class. They take effect at the next SELECT.
- Bursts repeat back to back (IDLE → SELECT → OFF) while any class stays eligible.
- Arithmetic: blink_cnt and target are BLINK_W bits wide and the counter never wraps. tick_cnt is clog2(OFF_TICKS+1) bits wide.

## Timing
- Reset values: health_led=1, seq_busy=0, seq_done=0, fault_present=0, active_class=0, fault_vec=0, divider=0, FSM=IDLE, last_class=NUM_CLASSES-1. The first round-robin pick is therefore the lowest eligible index.
- Reset is asynchronous: outputs take reset values immediately, including mid-burst.
- Latency:
  - class_in sampled at edge t → fault_vec/fault_present at t+1 → SELECT at t+2 (seq_busy high) → OFF at t+3.
  - active_class is valid from t+3.
- OFF length: between (OFF_TICKS-1)*CLK_DIV+1 and OFF_TICKS*CLK_DIV cycles, depending on divider phase.
- Every BLINK_ON and BLINK_OFF phase lasts exactly CLK_DIV cycles.
- seq_done is high in the cycle following the final BLINK_OFF tick, coincident with state IDLE.
- Inter-burst gap: 2 cycles (IDLE and SELECT) plus the OFF length.

## Test plan
Sim parameters for all scenarios: CLK_DIV=4, OFF_TICKS=2, default map.
- Priority: MODE=0, hold class 2 and class 9 (class_in bits nonzero) → active_class=9; 10 low pulses of 4 cycles, 4 cycles apart; seq_done once per burst; bursts repeat.
- Round-robin: MODE=1, hold classes 1 and 4 → bursts of 2, 5, 2, 5 pulses; active_class sequence 1, 4, 1, 4.
- Sticky: STICKY=1, class 3 high for 1 cycle → fault_present stays 1 and 4-pulse bursts repeat. Assert clear_faults mid-burst → that burst completes with 4 pulses, then IDLE; health_led stays 1 and fault_present=0.
- Live removal: STICKY=0, class 5 held, then dropped during the 3rd pulse → all 6 pulses complete, seq_done fires, FSM returns to IDLE and stays there.
- Async reset during BLINK_ON → health_led=1 and seq_busy=0 without a clock edge. After release with class 0 held → first low pulse appears no earlier than 3 cycles + 1 tick.
- Masked class: BLINK_MAP entry 7 = 0, only class 7 held → fault_present=1, seq_busy=0, health_led=1 indefinitely.

Source files
------------

// File: rtl/led_blink_code_mc.sv
// Multi-class health-LED blink-code sequencer: picks one active fault class and
// emits an OFF gap followed by N active-low pulses, N from a per-class blink map.
module led_blink_code_mc #(
  parameter int unsigned NUM_CLASSES = 11,
  parameter int unsigned CLASS_SIZE  = 8,
  parameter int unsigned BLINK_W     = 4,
  // Entry i = i+1 for the default 11-class, 4-bit map; override when resizing.
  parameter logic [NUM_CLASSES*BLINK_W-1:0] BLINK_MAP = 44'hBA9_8765_4321,
  parameter int unsigned CLK_DIV     = 12_500_000,
  parameter int unsigned OFF_TICKS   = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned STICKY      = 0,
  localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              sys_clk_i,
  input  logic                              reset_i,
  input  logic [NUM_CLASSES*CLASS_SIZE-1:0] class_in_i,
  input  logic                              clear_faults_i,
  output logic                              health_led_o,
  output logic [CW-1:0]                     active_class_o,
  output logic                              seq_busy_o,
  output logic                              seq_done_o,
  output logic                              fault_present_o
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned TW = $clog2(OFF_TICKS + 1);

  typedef enum logic [2:0] {StIdle, StSelect, StOff, StBlinkOn, StBlinkOff} state_e;

  state_e                 state_q, state_d;
  logic [NUM_CLASSES-1:0] ev_vec, eligible, fault_q, fault_d;
  logic [DW-1:0]          div_q, div_d;
  logic                   tick;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d, target_q, target_d, pick_map;
  logic [CW-1:0]          active_q, active_d, last_q, last_d, pick, rr_lo, rr_hi;
  logic                   rr_hit;
  logic                   led_q, done_q, done_d;

  always_comb begin
    ev_vec   = '0;
    eligible = '0;
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      ev_vec[i]   = |class_in_i[i*CLASS_SIZE +: CLASS_SIZE];
      eligible[i] = fault_q[i] & (BLINK_MAP[i*BLINK_W +: BLINK_W] != '0);
    end
  end

  // In sticky mode a new event in the clear cycle survives the clear.
  always_comb begin
    if (STICKY == 0 || clear_faults_i) begin
      fault_d = ev_vec;
    end else begin
      fault_d = fault_q | ev_vec;
    end
  end

  assign tick  = (div_q == DW'(CLK_DIV - 1));
  assign div_d = tick ? '0 : div_q + DW'(1);

  always_comb begin
    rr_lo  = '0;
    rr_hi  = '0;
    rr_hit = 1'b0;
    for (int i = int'(NUM_CLASSES) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        rr_lo = CW'(i);
        if (i > int'(last_q)) begin
          rr_hi  = CW'(i);
          rr_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick = '0;
    if (MODE == 0) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        if (eligible[i]) pick = CW'(i);
      end
    end else begin
      pick = rr_hit ? rr_hi : rr_lo;
    end
    pick_map = BLINK_MAP[int'(pick)*BLINK_W +: BLINK_W];
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    blink_cnt_d = blink_cnt_q;
    target_d    = target_q;
    active_d    = active_q;
    last_d      = last_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (|eligible) state_d = StSelect;
      end
      StSelect: begin
        if (|eligible) begin
          active_d    = pick;
          last_d      = pick;
          target_d    = pick_map;
          tick_cnt_d  = '0;
          blink_cnt_d = '0;
          state_d     = StOff;
        end else begin
          state_d = StIdle;
        end
      end
      StOff: begin
        if (tick) begin
          if (tick_cnt_q == TW'(OFF_TICKS - 1)) begin
            state_d = StBlinkOn;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      StBlinkOn: begin
        if (tick) state_d = StBlinkOff;
      end
      StBlinkOff: begin
        if (tick) begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          if (blink_cnt_d == target_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StBlinkOn;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      fault_q     <= '0;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      target_q    <= '0;
      active_q    <= '0;
      last_q      <= CW'(NUM_CLASSES - 1);
      led_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      target_q    <= target_d;
      active_q    <= active_d;
      last_q      <= last_d;
      // Registered so the LED tracks the BLINK_ON state with no input-to-pin path.
      led_q       <= (state_d != StBlinkOn);
      done_q      <= done_d;
    end
  end

  assign health_led_o    = led_q;
  assign active_class_o  = active_q;
  assign seq_busy_o      = (state_q != StIdle);
  assign seq_done_o      = done_q;
  assign fault_present_o = |fault_q;

endmodule
